// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter and its users.
package rf_arb_pkg;

   localparam int unsigned RF_ADDR_W = 5;
   localparam int unsigned RF_DATA_W = 32;
   localparam logic [RF_ADDR_W-1:0] RF_ZERO_REG = 5'd0;

   typedef struct packed {
      logic [RF_ADDR_W-1:0] addr;
      logic [RF_DATA_W-1:0] data;
   } rf_wr_t;

   // Round-robin successor of idx within 0..n-1.
   function automatic int unsigned rrNext(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
   parameter int unsigned N     = 2,
   parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] encIdx
);

   logic [IDX_W-1:0] cand;
   logic             found;

   always_comb begin
      grant  = '0;
      encIdx = '0;
      found  = 1'b0;
      cand   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = IDX_W'((32'(ptr) + k) % N);
         if (!found && req[cand]) begin
            grant[cand] = 1'b1;
            encIdx      = cand;
            found       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NUM_REQ writeback sources through
// one-entry holding buffers and a round-robin grant; flags read-after-write hazards.
module regfile_write_arbiter
   import rf_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ADDR_W  = RF_ADDR_W,
   parameter int unsigned DATA_W  = RF_DATA_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   input  logic [ADDR_W-1:0]          rd_addr1,
   input  logic [ADDR_W-1:0]          rd_addr2,
   output logic                       rf_we,
   output logic [ADDR_W-1:0]          rf_waddr,
   output logic [DATA_W-1:0]          rf_wdata,
   output logic                       pend1,
   output logic                       pend2
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_REG);

   logic [NUM_REQ-1:0] bufV;
   logic [ADDR_W-1:0]  bufA [NUM_REQ];
   logic [DATA_W-1:0]  bufD [NUM_REQ];
   logic [IDX_W-1:0]   ptr;
   logic [NUM_REQ-1:0] grant;
   logic [IDX_W-1:0]   encIdx;
   logic               anyGrant;
   logic [NUM_REQ-1:0] accept;

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) uArb (
      .req    (bufV),
      .ptr    (ptr),
      .grant  (grant),
      .encIdx (encIdx)
   );

   assign anyGrant = |grant;

   // A buffer can take a new write when empty or when it drains on this edge.
   assign req_ready = {NUM_REQ{~rst}} & (~bufV | grant);
   assign accept    = req_valid & req_ready;

   always_comb begin
      rf_we    = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      if (anyGrant && !rst) begin
         rf_we    = 1'b1;
         rf_waddr = bufA[encIdx];
         rf_wdata = bufD[encIdx];
      end
   end

   // Granted entries still count: the RF only updates at the edge.
   always_comb begin
      pend1 = 1'b0;
      pend2 = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (bufV[i] && (bufA[i] == rd_addr1) && (rd_addr1 != ZERO_ADDR)) pend1 = 1'b1;
         if (bufV[i] && (bufA[i] == rd_addr2) && (rd_addr2 != ZERO_ADDR)) pend2 = 1'b1;
      end
   end

   // Writes to the zero register complete the handshake but never occupy a buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bufV <= '0;
         ptr  <= '0;
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            bufA[i] <= '0;
            bufD[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
               bufV[i] <= (req_addr[i*ADDR_W +: ADDR_W] != ZERO_ADDR);
               bufA[i] <= req_addr[i*ADDR_W +: ADDR_W];
               bufD[i] <= req_data[i*DATA_W +: DATA_W];
            end else if (grant[i]) begin
               bufV[i] <= 1'b0;
            end
         end
         if (anyGrant) ptr <= IDX_W'(rrNext(32'(encIdx), NUM_REQ));
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter with two requesters.
module tb_regfile_write_arbiter;
   import rf_arb_pkg::*;

   logic        clk;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [9:0]  req_addr;
   logic [63:0] req_data;
   logic [4:0]  rd_addr1;
   logic [4:0]  rd_addr2;
   logic        rf_we;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic        pend1;
   logic        pend2;

   int nChecks = 0;
   int nFail   = 0;
   rf_wr_t q0[$];
   rf_wr_t q1[$];
   logic [31:0] rfModel [32];
   int a0Idx, a1Idx;

   regfile_write_arbiter #(.NUM_REQ(2), .ADDR_W(5), .DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .rd_addr1  (rd_addr1),
      .rd_addr2  (rd_addr2),
      .rf_we     (rf_we),
      .rf_waddr  (rf_waddr),
      .rf_wdata  (rf_wdata),
      .pend1     (pend1),
      .pend2     (pend2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      if (obs !== exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Drive one cycle's inputs at negedge, then score the commit and handshakes due at the next posedge.
   task automatic drive(input logic [1:0] v, input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1);
      rf_wr_t e;
      @(negedge clk);
      req_valid = v;
      req_addr  = {a1, a0};
      req_data  = {d1, d0};
      #1;
      if (rf_we === 1'b1) begin
         if (q0.size() > 0 && q0[0].addr == rf_waddr) begin
            e = q0.pop_front();
            chk("commit_data_r0", rf_wdata, e.data);
         end else if (q1.size() > 0 && q1[0].addr == rf_waddr) begin
            e = q1.pop_front();
            chk("commit_data_r1", rf_wdata, e.data);
         end else begin
            chk("commit_unexpected_addr", 32'(rf_waddr), (q0.size() > 0) ? 32'(q0[0].addr) : 32'hFFFF_FFFF);
         end
         rfModel[rf_waddr] = rf_wdata;
      end
      if (v[0] && req_ready[0] === 1'b1 && a0 != 5'd0) q0.push_back('{addr: a0, data: d0});
      if (v[1] && req_ready[1] === 1'b1 && a1 != 5'd0) q1.push_back('{addr: a1, data: d1});
   endtask

   task automatic idle();
      drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rfModel[i] = 32'd0;
      rst = 1'b1;
      req_valid = 2'b00;
      req_addr = '0;
      req_data = '0;
      rd_addr1 = 5'd0;
      rd_addr2 = 5'd0;
      #1;
      chk("reset_we", 32'(rf_we), 32'd0);
      chk("reset_ready", 32'(req_ready), 32'd0);
      chk("reset_waddr", 32'(rf_waddr), 32'd0);
      chk("reset_wdata", rf_wdata, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Single write with read-port hazard
      rd_addr1 = 5'd5;
      drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0);
      chk("single_ready", 32'(req_ready), 32'b11);
      chk("single_we_pre", 32'(rf_we), 32'd0);
      chk("single_pend_pre", 32'(pend1), 32'd0);
      idle();
      chk("single_we", 32'(rf_we), 32'd1);
      chk("single_waddr", 32'(rf_waddr), 32'd5);
      chk("single_wdata", rf_wdata, 32'hDEADBEEF);
      chk("single_pend1", 32'(pend1), 32'd1);
      idle();
      chk("single_we_post", 32'(rf_we), 32'd0);
      chk("single_pend_post", 32'(pend1), 32'd0);
      chk("single_rf5", rfModel[5], 32'hDEADBEEF);

      // Contention: ptr is 1 after the r0 commit, so r1 is served first
      rd_addr1 = 5'd0;
      a0Idx = 1;
      a1Idx = 17;
      for (int k = 0; k < 8; k++) begin
         drive(2'b11, 5'(a0Idx), 32'hA000_0000 + 32'(a0Idx), 5'(a1Idx), 32'hB000_0000 + 32'(a1Idx));
         if (k == 0) begin
            chk("cont_ready0", 32'(req_ready), 32'b11);
            chk("cont_we0", 32'(rf_we), 32'd0);
         end else begin
            chk("cont_ready", 32'(req_ready), (k % 2 == 1) ? 32'b10 : 32'b01);
            chk("cont_we", 32'(rf_we), 32'd1);
            chk("cont_grant", (rf_waddr >= 5'd16) ? 32'd1 : 32'd0, (k % 2 == 1) ? 32'd1 : 32'd0);
         end
         if (req_ready[0]) a0Idx++;
         if (req_ready[1]) a1Idx++;
      end
      for (int k = 0; k < 10 && (q0.size() + q1.size()) > 0; k++) idle();
      chk("cont_drained", 32'(q0.size() + q1.size()), 32'd0);
      idle();

      // Zero register write is swallowed
      drive(2'b10, 5'd0, 32'd0, 5'd0, 32'h1234);
      chk("zero_ready", 32'(req_ready[1]), 32'd1);
      chk("zero_we0", 32'(rf_we), 32'd0);
      idle();
      chk("zero_we1", 32'(rf_we), 32'd0);
      chk("zero_pend", 32'({pend1, pend2}), 32'd0);
      chk("zero_rf0", rfModel[0], 32'd0);

      // Back-to-back on a single requester
      for (int k = 0; k < 4; k++) begin
         drive(2'b01, 5'(3 + k), 32'hC000_0000 + 32'(k), 5'd0, 32'd0);
         chk("b2b_ready", 32'(req_ready[0]), 32'd1);
         if (k > 0) chk("b2b_waddr", rf_we ? 32'(rf_waddr) : 32'hFF, 32'(2 + k));
      end
      idle();
      chk("b2b_last", rf_we ? 32'(rf_waddr) : 32'hFF, 32'd6);
      idle();
      chk("b2b_done", 32'(rf_we), 32'd0);

      // Hazard: r1 buffers addr 9 while r0 is being granted
      rd_addr1 = 5'd10;
      rd_addr2 = 5'd9;
      drive(2'b01, 5'd10, 32'h0000_0010, 5'd0, 32'd0);
      chk("haz_pend2_c0", 32'(pend2), 32'd0);
      drive(2'b10, 5'd0, 32'd0, 5'd9, 32'h0000_0009);
      chk("haz_waddr_c1", 32'(rf_waddr), 32'd10);
      chk("haz_pend1_c1", 32'(pend1), 32'd1);
      chk("haz_pend2_c1", 32'(pend2), 32'd0);
      idle();
      chk("haz_waddr_c2", 32'(rf_waddr), 32'd9);
      chk("haz_pend2_c2", 32'(pend2), 32'd1);
      idle();
      chk("haz_pend2_c3", 32'(pend2), 32'd0);

      // Mid-run reset with both buffers full and ptr at 1
      rd_addr1 = 5'd8;
      rd_addr2 = 5'd25;
      drive(2'b01, 5'd7, 32'h7777, 5'd0, 32'd0);
      drive(2'b11, 5'd8, 32'h8888, 5'd25, 32'h2525);
      chk("rst_fill_ready", 32'(req_ready), 32'b11);
      @(negedge clk);
      req_valid = 2'b00;
      chk("rst_pre_pend", 32'({pend1, pend2}), 32'b11);
      rst = 1'b1;
      #1;
      chk("rst_mid_we", 32'(rf_we), 32'd0);
      chk("rst_mid_ready", 32'(req_ready), 32'd0);
      chk("rst_mid_pend", 32'({pend1, pend2}), 32'd0);
      q0.delete();
      q1.delete();
      @(negedge clk);
      rst = 1'b0;
      drive(2'b11, 5'd2, 32'h0202, 5'd30, 32'h3030);
      chk("rst_post_ready", 32'(req_ready), 32'b11);
      chk("rst_post_we", 32'(rf_we), 32'd0);
      idle();
      chk("rst_ptr0", rf_we ? 32'(rf_waddr) : 32'hFF, 32'd2);
      for (int k = 0; k < 10 && (q0.size() + q1.size()) > 0; k++) idle();
      chk("final_drained", 32'(q0.size() + q1.size()), 32'd0);
      chk("final_rf8_untouched", rfModel[8], 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
